pcie_tx_arb: RTL and testbench

PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

---
 rtl/pcie_tx_arb.sv | 188 ++++++++++++++++++
 tb/tb_pcie_tx_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arb.sv
// -----------------------------------------------------------------------------
// pcie_tx_arb
//   Transmit-side TLP arbiter for three requesters (Posted, NonPosted,
//   Completion). It grants one requester at a time, round-robin. A requester
//   can only be granted when the link is ready and its flow-control type holds
//   enough header and data credits. Credits are taken on the grant edge. The
//   grant is held until the granted TLP's last beat is seen.
//
// Ports
//   Clk        : clock; all state changes on the rising edge
//   Reset      : synchronous, active-high reset
//   Req[2:0]   : level requests; bit0=Posted, bit1=NonPosted, bit2=Completion
//   ReqLen     : payload length in DW, 11 bits per requester
//   LinkReady  : link trained and accepting TLPs
//   XferVal    : beat valid from the granted requester
//   XferEop    : last beat of the granted TLP (qualified by XferVal)
//   FcInit     : pulse; load credits of FcType (a zero value means infinite)
//   FcUpdate   : pulse; add credits to FcType (saturating)
//   FcType     : 0=P, 1=NP, 2=Cpl, 3=ignored
//   FcHdr      : header credit value
//   FcData     : data credit value (1 credit = 4 DW)
//   Gnt[2:0]   : registered one-hot grant
//   Busy       : high while a granted TLP is in flight
// -----------------------------------------------------------------------------
module pcie_tx_arb #(
  parameter int HCRED_W = 8,
  parameter int DCRED_W = 12
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [2:0]         Req,
  input  logic [32:0]        ReqLen,
  input  logic               LinkReady,
  input  logic               XferVal,
  input  logic               XferEop,
  input  logic               FcInit,
  input  logic               FcUpdate,
  input  logic [1:0]         FcType,
  input  logic [HCRED_W-1:0] FcHdr,
  input  logic [DCRED_W-1:0] FcData,
  output logic [2:0]         Gnt,
  output logic               Busy
);

  typedef enum logic {IDLE, XFER} state_e;

  // A 1024 DW TLP needs 256 data credits, so the need value is 9 bits wide.
  localparam int NEED_W = 9;
  // The sums are 2 bits wider than either operand. This keeps count + add
  // from overflowing before the saturation check is made.
  localparam int HSUM_W = HCRED_W + 2;
  localparam int DSUM_W = ((DCRED_W > NEED_W) ? DCRED_W : NEED_W) + 2;
  localparam logic [HSUM_W-1:0] HMAX = {2'b00, {HCRED_W{1'b1}}};
  localparam logic [DSUM_W-1:0] DMAX = DSUM_W'({DCRED_W{1'b1}});

  state_e                    state_q, state_d;
  logic [2:0]                gnt_q, gnt_d;
  logic [1:0]                last_q, last_d;
  logic [2:0][HCRED_W-1:0]   hdr_q, hdr_d;
  logic [2:0][DCRED_W-1:0]   data_q, data_d;
  logic [2:0]                hdr_inf_q, hdr_inf_d;
  logic [2:0]                data_inf_q, data_inf_d;

  logic [2:0][NEED_W-1:0]    need;
  logic [2:0]                eligible;
  logic [2:0]                grant_now;   // grant issued on the coming edge

  // Requester i draws on the credit type with the same index.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      need[i]     = NEED_W'((ReqLen[11*i +: 11] + 11'd3) >> 2);
      eligible[i] = Req[i] & LinkReady
                  & (hdr_inf_q[i] | (hdr_q[i] != '0))
                  & (data_inf_q[i] | (DSUM_W'(data_q[i]) >= DSUM_W'(need[i])));
    end
  end

  // Round-robin pick. The search starts just after the last granted index.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every combinational output gets a default before any branch.
    // Without the default, some paths leave the output unassigned, and
    // synthesis then infers a latch.
    grant_now = '0;
    last_d    = last_q;
    found     = 1'b0;
    idx       = 0;
    if (state_q == IDLE) begin
      for (int k = 0; k < 3; k++) begin
        idx = (int'(last_q) + 1 + k) % 3;
        if (!found && eligible[idx]) begin
          grant_now[idx] = 1'b1;
          last_d         = 2'(idx);
          found          = 1'b1;
        end
      end
    end
  end

  // FSM next state and grant register.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|grant_now) begin
          state_d = XFER;
          gnt_d   = grant_now;
        end
      end
      XFER: begin
        if (XferVal && XferEop) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Credit bookkeeping. FcInit replaces the counters outright.
  // Otherwise update and deduction are merged into one saturating sum.
  always_comb begin
    logic [HSUM_W-1:0] hsum;
    logic [DSUM_W-1:0] dsum;
    logic              upd;
    hdr_d      = hdr_q;
    data_d     = data_q;
    hdr_inf_d  = hdr_inf_q;
    data_inf_d = data_inf_q;
    hsum       = '0;
    dsum       = '0;
    upd        = 1'b0;
    for (int t = 0; t < 3; t++) begin
      upd  = FcUpdate && (FcType == 2'(t));
      hsum = HSUM_W'(hdr_q[t])
           + (upd ? HSUM_W'(FcHdr) : HSUM_W'(0))
           - (grant_now[t] ? HSUM_W'(1) : HSUM_W'(0));
      dsum = DSUM_W'(data_q[t])
           + (upd ? DSUM_W'(FcData) : DSUM_W'(0))
           - (grant_now[t] ? DSUM_W'(need[t]) : DSUM_W'(0));
      if (FcInit && (FcType == 2'(t))) begin
        hdr_d[t]      = FcHdr;
        data_d[t]     = FcData;
        hdr_inf_d[t]  = (FcHdr == '0);
        data_inf_d[t] = (FcData == '0);
      end else begin
        if (!hdr_inf_q[t]) begin
          hdr_d[t] = (hsum > HMAX) ? '1 : HCRED_W'(hsum);
        end
        if (!data_inf_q[t]) begin
          data_d[t] = (dsum > DMAX) ? '1 : DCRED_W'(dsum);
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments.
  // All registers then update together at the edge, so no register sees
  // another's new value in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= 2'd2;
      hdr_q      <= '0;
      data_q     <= '0;
      hdr_inf_q  <= '0;
      data_inf_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      hdr_q      <= hdr_d;
      data_q     <= data_d;
      hdr_inf_q  <= hdr_inf_d;
      data_inf_q <= data_inf_d;
    end
  end

  assign Gnt  = gnt_q;
  assign Busy = (state_q == XFER);

endmodule

// File: tb/tb_pcie_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_pcie_tx_arb
//   Directed bench for pcie_tx_arb. The expected values are worked out by hand.
//   Inputs are driven 1 ns after the rising edge, and outputs are sampled at
//   the same point.
// -----------------------------------------------------------------------------
module tb_pcie_tx_arb;

  logic        Clk;
  logic        Reset;
  logic [2:0]  Req;
  logic [32:0] ReqLen;
  logic        LinkReady;
  logic        XferVal;
  logic        XferEop;
  logic        FcInit;
  logic        FcUpdate;
  logic [1:0]  FcType;
  logic [7:0]  FcHdr;
  logic [11:0] FcData;
  logic [2:0]  Gnt;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;

  pcie_tx_arb #(.HCRED_W(8), .DCRED_W(12)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqLen(ReqLen),
    .LinkReady(LinkReady), .XferVal(XferVal), .XferEop(XferEop),
    .FcInit(FcInit), .FcUpdate(FcUpdate), .FcType(FcType),
    .FcHdr(FcHdr), .FcData(FcData), .Gnt(Gnt), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fc_init(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    FcInit = 1'b1; FcType = t; FcHdr = h; FcData = d;
    tick();
    FcInit = 1'b0; FcHdr = '0; FcData = '0;
  endtask

  task automatic eop();
    XferVal = 1'b1; XferEop = 1'b1;
    tick();
    XferVal = 1'b0; XferEop = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Req = '0; ReqLen = '0; LinkReady = 1'b1;
    XferVal = 1'b0; XferEop = 1'b0; FcInit = 1'b0; FcUpdate = 1'b0;
    FcType = '0; FcHdr = '0; FcData = '0;
    tick(); tick();
    Reset = 1'b0;
    check("rst_gnt",  32'(Gnt), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hdrP", 32'(dut.hdr_q[0]), 32'd0);

    // Basic grant with credit deduction: 16 DW needs 4 data credits.
    fc_init(2'd0, 8'd4, 12'd8);
    Req = 3'b001; ReqLen = {22'd0, 11'd16};
    tick();
    check("t1_gnt",   32'(Gnt), 32'b001);
    check("t1_busy",  32'(Busy), 32'd1);
    check("t1_hdrP",  32'(dut.hdr_q[0]), 32'd3);
    check("t1_dataP", 32'(dut.data_q[0]), 32'd4);
    XferVal = 1'b1; XferEop = 1'b0;
    tick();
    check("t1_val_noeop", 32'(Gnt), 32'b001);
    Req = '0;
    eop();
    check("t1_eop_gnt",  32'(Gnt), 32'd0);
    check("t1_eop_busy", 32'(Busy), 32'd0);

    // Round-robin with Req held high and one idle cycle between grants.
    do_reset();
    fc_init(2'd0, 8'd8, 12'd64);
    fc_init(2'd1, 8'd8, 12'd64);
    fc_init(2'd2, 8'd8, 12'd64);
    ReqLen = {11'd4, 11'd4, 11'd4};
    Req = 3'b111;
    tick();
    check("rr_g1", 32'(Gnt), 32'b001);
    eop();
    check("rr_idle1", 32'(Gnt), 32'd0);
    tick();
    check("rr_g2", 32'(Gnt), 32'b010);
    eop();
    check("rr_idle2", 32'(Gnt), 32'd0);
    tick();
    check("rr_g3", 32'(Gnt), 32'b100);
    eop();
    check("rr_idle3", 32'(Gnt), 32'd0);
    tick();
    check("rr_g4", 32'(Gnt), 32'b001);
    Req = '0;
    eop();
    check("rr_hdrP",  32'(dut.hdr_q[0]), 32'd6);
    check("rr_dataP", 32'(dut.data_q[0]), 32'd62);
    check("rr_dataNP", 32'(dut.data_q[1]), 32'd63);

    // Data credits short by one; an update brings them up to the need.
    fc_init(2'd0, 8'd4, 12'd2);
    ReqLen = {22'd0, 11'd12};
    Req = 3'b001;
    tick();
    check("short_g_a", 32'(Gnt), 32'd0);
    tick();
    check("short_g_b", 32'(Gnt), 32'd0);
    FcUpdate = 1'b1; FcType = 2'd0; FcHdr = 8'd0; FcData = 12'd1;
    tick();
    FcUpdate = 1'b0; FcData = '0;
    check("short_upd_edge", 32'(Gnt), 32'd0);
    tick();
    check("short_granted", 32'(Gnt), 32'b001);
    check("short_dataP",   32'(dut.data_q[0]), 32'd0);
    check("short_hdrP",    32'(dut.hdr_q[0]), 32'd3);
    Req = '0;
    eop();

    // Saturation on update.
    fc_init(2'd0, 8'd250, 12'd4000);
    FcUpdate = 1'b1; FcType = 2'd0; FcHdr = 8'd10; FcData = 12'd200;
    tick();
    FcUpdate = 1'b0;
    check("sat_hdr",  32'(dut.hdr_q[0]), 32'd255);
    check("sat_data", 32'(dut.data_q[0]), 32'd4095);

    // FcInit takes priority over FcUpdate on the same edge.
    FcInit = 1'b1; FcUpdate = 1'b1; FcType = 2'd1; FcHdr = 8'd5; FcData = 12'd7;
    tick();
    FcInit = 1'b0; FcUpdate = 1'b0;
    check("prio_hdrNP",  32'(dut.hdr_q[1]), 32'd5);
    check("prio_dataNP", 32'(dut.data_q[1]), 32'd7);

    // Update and deduction on the same edge.
    fc_init(2'd0, 8'd3, 12'd10);
    ReqLen = {22'd0, 11'd8};
    Req = 3'b001;
    FcUpdate = 1'b1; FcType = 2'd0; FcHdr = 8'd2; FcData = 12'd5;
    tick();
    FcUpdate = 1'b0;
    check("both_gnt",  32'(Gnt), 32'b001);
    check("both_hdr",  32'(dut.hdr_q[0]), 32'd4);
    check("both_data", 32'(dut.data_q[0]), 32'd13);
    Req = '0;
    eop();

    // FcType 3 is ignored.
    fc_init(2'd3, 8'd0, 12'd0);
    check("t3_hdrinf",  32'(dut.hdr_inf_q), 32'd0);
    check("t3_datainf", 32'(dut.data_inf_q), 32'd0);

    // Infinite Completion credits: 20 maximum-length TLPs back to back.
    fc_init(2'd2, 8'd0, 12'd0);
    ReqLen = {11'd1024, 22'd0};
    Req = 3'b100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("inf_g%0d", i), 32'(Gnt), 32'b100);
      XferVal = 1'b1; XferEop = 1'b1;
      if (i == 19) Req = '0;
      tick();
      XferVal = 1'b0; XferEop = 1'b0;
      check($sformatf("inf_idle%0d", i), 32'(Gnt), 32'd0);
    end
    check("inf_hdr",     32'(dut.hdr_q[2]), 32'd0);
    check("inf_data",    32'(dut.data_q[2]), 32'd0);
    check("inf_hdrflag", 32'(dut.hdr_inf_q), 32'b100);

    // Reset during XFER; afterwards NP has no credits and is never granted.
    do_reset();
    fc_init(2'd1, 8'd8, 12'd64);
    ReqLen = {11'd0, 11'd4, 11'd0};
    Req = 3'b010;
    tick();
    check("rx_gnt", 32'(Gnt), 32'b010);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rx_gnt_clr", 32'(Gnt), 32'd0);
    check("rx_busy",    32'(Busy), 32'd0);
    tick(); tick();
    check("rx_nocred", 32'(Gnt), 32'd0);
    check("rx_hdrNP",  32'(dut.hdr_q[1]), 32'd0);
    Req = '0;

    // LinkReady gating, XferVal/XferEop ignored in IDLE, and grant hold.
    fc_init(2'd0, 8'd8, 12'd64);
    ReqLen = {22'd0, 11'd4};
    LinkReady = 1'b0; Req = 3'b001;
    tick(); tick();
    check("lr_nogrant", 32'(Gnt), 32'd0);
    LinkReady = 1'b1; XferVal = 1'b1; XferEop = 1'b1;
    tick();
    XferVal = 1'b0; XferEop = 1'b0;
    check("lr_grant", 32'(Gnt), 32'b001);
    LinkReady = 1'b0; Req = '0;
    tick();
    check("lr_hold",      32'(Gnt), 32'b001);
    check("lr_hold_busy", 32'(Busy), 32'd1);
    XferVal = 1'b1; XferEop = 1'b0;
    tick();
    check("lr_hold2", 32'(Gnt), 32'b001);
    eop();
    check("lr_release", 32'(Gnt), 32'd0);
    LinkReady = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
